// File: rtl/result_bcd_conv_pkg.sv
// rtl/result_bcd_conv_pkg.sv - shared widths and FSM encodings for the result BCD converter
//
// Purpose: defaults shared by the ALU, this converter and the display driver,
//          plus the converter state encoding.
// Ports:   none (package)
package result_bcd_conv_pkg;

  localparam int CALC_RES_W = 16;  // ALU result width
  localparam int CALC_NDIG  = 5;   // decimal digits shown on the display

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01
  } conv_state_t;

endpackage

// File: rtl/result_bcd_conv_add3_cell.sv
// rtl/result_bcd_conv_add3_cell.sv - double-dabble add-3 correction for one BCD digit
//
// Purpose: pre-shift correction so a digit >= 5 carries into the next digit after the shift.
// Ports:   d  in  4  BCD digit before correction
//          q  out 4  corrected digit (d >= 5 ? d + 3 : d)
module bcd_add3_cell (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/result_bcd_conv.sv
// rtl/result_bcd_conv.sv - sequential double-dabble of an ALU result into sign + BCD digits
//
// Purpose: converts one IN_W-bit result per accept into NDIG BCD digits, one bit per clock.
// Ports:   clk        in   1       clock
//          rst_n      in   1       asynchronous active-low reset
//          clr        in   1       synchronous abort to IDLE, outputs keep last values
//          in_valid   in   1       in_data valid
//          in_ready   out  1       high only in IDLE
//          in_data    in   IN_W    value to convert
//          out_valid  out  1       one-cycle pulse when outputs update
//          out_neg    out  1       result was negative (SIGNED only)
//          out_bcd    out  4*NDIG  digit i at [4i+3:4i], digit 0 = units
//          out_blank  out  NDIG    bit i set when digit i is a leading zero
module result_bcd_conv
  import result_bcd_conv_pkg::*;
#(
  parameter int IN_W   = CALC_RES_W,
  parameter int NDIG   = CALC_NDIG,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic              out_neg,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [NDIG-1:0]   out_blank
);

  localparam int ACC_W = 4 * NDIG;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  conv_state_t       state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [IN_W-1:0]   mag;
  logic [ACC_W-1:0]  acc;
  logic              neg;

  logic              accept;
  logic              last_step;
  logic              in_neg;
  logic [IN_W-1:0]   in_mag;
  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_sh;
  logic [NDIG-1:0]   blank_nx;
  logic              zero_run;
  logic              digits_ok;

  // Magnitude of the most negative value is 2^(IN_W-1), which still fits unsigned.
  assign in_neg = (SIGNED != 0) && in_data[IN_W-1];
  assign in_mag = in_neg ? (~in_data + {{(IN_W-1){1'b0}}, 1'b1}) : in_data;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .d (acc[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  // Corrected accumulator shifted left, taking in the next magnitude MSB.
  assign acc_sh = {acc_adj[ACC_W-2:0], mag[IN_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !clr) begin
          accept   = 1'b1;
          state_nx = ST_CONV;
        end
      end
      ST_CONV: begin
        if (clr) begin
          state_nx = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          last_step = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Leading-zero mask of the post-step value; the units digit is never blanked.
  always_comb begin
    blank_nx = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run    = zero_run & (acc_sh[4*i +: 4] == 4'd0);
      blank_nx[i] = zero_run;
    end
  end

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_sh[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mag       <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_bcd   <= '0;
      out_blank <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        neg <= in_neg;
        mag <= in_mag;
        acc <= '0;
        cnt <= '0;
      end else if (state == ST_CONV && !clr) begin
        acc <= acc_sh;
        mag <= {mag[IN_W-2:0], 1'b0};
        cnt <= cnt + 1'b1;
        if (last_step) begin
          out_bcd   <= acc_sh;
          out_neg   <= neg;
          out_blank <= blank_nx;
          out_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && last_step) begin
      assert (digits_ok);
    end
  end

endmodule
